// File: rtl/edge_detection_pkg.sv
// Shared definitions for the edge-detection pipeline: output FSM state
// encoding, default image geometry and the G-memory address width.
package edge_detection_pkg;

  localparam int IMG_W         = 64;
  localparam int IMG_H         = 64;
  localparam int DEF_DATA_W    = 8;
  localparam int DEF_OUT_COUNT = (IMG_W - 2) * (IMG_H - 2);
  localparam int DEF_ADDR_W    = 12;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_STREAM   = 2'd1,
    ST_DONE     = 2'd2,
    ST_WAIT_LOW = 2'd3
  } out_state_t;

  // A new read may be issued only when every outstanding word (queued plus
  // the one still coming back from memory) leaves a free FIFO slot.
  function automatic logic fifo_has_room(input logic [1:0] count, input logic inflight);
    return ({1'b0, count} + {2'b00, inflight}) < 3'd3;
  endfunction

endpackage

// File: rtl/edge_stream_fifo.sv
// Three-entry synchronous show-ahead FIFO buffering G-memory read data
// ahead of the Avalon-ST output. Push and pop in the same cycle are legal.
module edge_stream_fifo #(
  parameter int DATA_W = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_push_data,
  input  logic              i_pop,
  output logic [DATA_W-1:0] o_head,
  output logic              o_full,
  output logic              o_empty,
  output logic [1:0]        o_count
);

  localparam logic [1:0] LAST_IDX = 2'd2;

  logic [DATA_W-1:0] r_mem [0:2];
  logic [1:0]        r_wr_ptr;
  logic [1:0]        r_rd_ptr;
  logic [1:0]        r_count;
  logic              w_push_ok;
  logic              w_pop_ok;

  assign o_full    = (r_count == 2'd3);
  assign o_empty   = (r_count == 2'd0);
  assign o_count   = r_count;
  assign o_head    = r_mem[r_rd_ptr];
  assign w_push_ok = i_push && !o_full;
  assign w_pop_ok  = i_pop && !o_empty;

  // Storage array; contents are don't-care while the FIFO is empty.
  always_ff @(posedge i_clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= i_push_data;
    end
  end

  // Pointer and occupancy bookkeeping with wrap at the third entry.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= 2'd0;
      r_rd_ptr <= 2'd0;
      r_count  <= 2'd0;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= (r_wr_ptr == LAST_IDX) ? 2'd0 : r_wr_ptr + 2'd1;
      end
      if (w_pop_ok) begin
        r_rd_ptr <= (r_rd_ptr == LAST_IDX) ? 2'd0 : r_rd_ptr + 2'd1;
      end
      if (w_push_ok && !w_pop_ok) begin
        r_count <= r_count + 2'd1;
      end else if (!w_push_ok && w_pop_ok) begin
        r_count <= r_count - 2'd1;
      end
    end
  end

endmodule

// File: rtl/edge_output_streamer.sv
// Reads the completed G memory sequentially and emits it as one Avalon-ST
// packet with backpressure, then pulses outputSent_o to the controller.
// Optional build macro EDGE_OUT_THRESH_EN adds thresh_i and turns the
// output into a binary edge map (all-ones where gradient >= threshold).
module edge_output_streamer
  import edge_detection_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int OUT_COUNT = DEF_OUT_COUNT,
  parameter int ADDR_W    = DEF_ADDR_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              dataAvailable_i,
`ifdef EDGE_OUT_THRESH_EN
  input  logic [DATA_W-1:0] thresh_i,
`endif
  output logic [ADDR_W-1:0] memGaddr_o,
  input  logic [DATA_W-1:0] memGrdData_i,
  output logic              memGrd_o,
  output logic [DATA_W-1:0] avst_data_o,
  output logic              avst_valid_o,
  input  logic              avst_ready_i,
  output logic              avst_sop_o,
  output logic              avst_eop_o,
  output logic              outputSent_o,
  output logic              busy_o
);

  // Counters carry one extra bit so "all reads issued" (== OUT_COUNT) is
  // representable even when OUT_COUNT == 2**ADDR_W.
  localparam logic [ADDR_W:0]   CNT_END   = (ADDR_W + 1)'(OUT_COUNT);
  localparam logic [ADDR_W:0]   CNT_LAST  = (ADDR_W + 1)'(OUT_COUNT - 1);
  localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(OUT_COUNT - 1);

  out_state_t        r_state;
  logic [ADDR_W:0]   r_addr;
  logic [ADDR_W:0]   r_beat;
  logic              r_inflight;
  logic              w_issue;
  logic              w_xfer;
  logic              w_last_xfer;
  logic              w_valid;
  logic [DATA_W-1:0] w_head;
  logic [DATA_W-1:0] w_beat_data;
  logic              w_full;
  logic              w_empty;
  logic [1:0]        w_count;

  assign w_issue     = (r_state == ST_STREAM) && (r_addr < CNT_END)
                       && fifo_has_room(w_count, r_inflight);
  assign w_valid     = !w_empty;
  assign w_xfer      = w_valid && avst_ready_i;
  assign w_last_xfer = w_xfer && (r_beat == CNT_LAST);

  edge_stream_fifo #(
    .DATA_W (DATA_W)
  ) u_fifo (
    .i_clk       (clk_i),
    .i_rst       (rst_i),
    .i_push      (r_inflight),
    .i_push_data (memGrdData_i),
    .i_pop       (w_xfer),
    .o_head      (w_head),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_count     (w_count)
  );

`ifdef EDGE_OUT_THRESH_EN
  logic [DATA_W-1:0] r_thresh;

  // Threshold is frozen for the whole packet at the start of streaming.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_thresh <= '0;
    end else if (r_state == ST_IDLE && dataAvailable_i) begin
      r_thresh <= thresh_i;
    end
  end

  assign w_beat_data = (w_head >= r_thresh) ? '1 : '0;
`else
  assign w_beat_data = w_head;
`endif

  // Packet sequencer: read issue, beat counting and the controller handshake.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= ST_IDLE;
      r_addr     <= '0;
      r_beat     <= '0;
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= w_issue;
      case (r_state)
        ST_IDLE: begin
          r_addr <= '0;
          r_beat <= '0;
          if (dataAvailable_i) begin
            r_state <= ST_STREAM;
          end
        end
        ST_STREAM: begin
          if (w_issue) begin
            r_addr <= r_addr + CNT_ONE;
          end
          if (w_xfer) begin
            r_beat <= r_beat + CNT_ONE;
          end
          if (w_last_xfer) begin
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          r_state <= ST_WAIT_LOW;
        end
        default: begin
          if (!dataAvailable_i) begin
            r_state <= ST_IDLE;
          end
        end
      endcase
    end
  end

  assign memGrd_o     = w_issue;
  assign memGaddr_o   = (r_addr < CNT_END) ? r_addr[ADDR_W-1:0] : ADDR_LAST;
  assign avst_valid_o = w_valid;
  assign avst_data_o  = w_valid ? w_beat_data : '0;
  assign avst_sop_o   = w_valid && (r_beat == '0);
  assign avst_eop_o   = w_valid && (r_beat == CNT_LAST);
  assign outputSent_o = (r_state == ST_DONE);
  assign busy_o       = (r_state != ST_IDLE);

endmodule

// File: doc/edge_output_streamer.md
# edge_output_streamer

Downstream stage of the edge-detection controller. Once the gradient memory (G memory) holds a complete result, this block reads it sequentially and emits it as one Avalon-ST packet with backpressure. After the last beat is accepted it returns a one-cycle `outputSent` pulse to the controller. It owns the G-memory read address while the controller is in its output-giving phase.

## Interface
Parameters:
- `DATA_W`, 8 — pixel/gradient width
- `OUT_COUNT`, 3844 — beats per packet, (64-2)*(64-2); must be ≥1
- `ADDR_W`, 12 — G-memory address and beat-counter width; must satisfy 2^ADDR_W ≥ `OUT_COUNT`

Ports:
- `clk_i`  in  1  — single clock, all logic on its rising edge
- `rst_i`  in  1  — synchronous, active-high reset
- `dataAvailable_i`  in  1  — controller level: G memory complete, output phase active
- `memGaddr_o`  out  ADDR_W  — G-memory read address
- `memGrdData_i`  in  DATA_W  — G-memory read data, valid exactly 1 cycle after `memGaddr_o` is presented with `memGrd_o`
- `memGrd_o`  out  1  — read strobe
- `avst_data_o`  out  DATA_W  — stream data
- `avst_valid_o`  out  1  — stream valid
- `avst_ready_i`  in  1  — sink ready; beat transfers when valid&ready
- `avst_sop_o`  out  1  — high with beat 0
- `avst_eop_o`  out  1  — high with beat `OUT_COUNT`-1
- `outputSent_o`  out  1  — one-cycle pulse after the last beat transfers
- `busy_o`  out  1  — high in any state except IDLE

## Operation
- Reset values: all outputs 0, state IDLE, FIFO empty, address and beat counters 0, in-flight flag 0.
- FSM states:
  - IDLE: `dataAvailable_i`=1 → STREAM; counters cleared.
  - STREAM: reads are issued and beats are emitted. Transfer of beat `OUT_COUNT`-1 → DONE.
  - DONE: `outputSent_o`=1 for this cycle only → WAIT_LOW.
  - WAIT_LOW: `dataAvailable_i`=0 → IDLE. This prevents a re-trigger on a stale level.
- Read issue, in STREAM only:
  - Issue when the read address < `OUT_COUNT` and FIFO occupancy + in-flight < 3. Pop in the same cycle is not credited.
  - On issue: `memGrd_o`=1, `memGaddr_o`=current address, then address += 1. The in-flight flag sets for one cycle.
  - Once all reads are issued, `memGaddr_o` holds `OUT_COUNT`-1 and `memGrd_o` stays 0.
- Returning data is pushed into a 3-entry FIFO (sub-module). `avst_*` is driven from the FIFO head; `avst_valid_o` = FIFO not empty.
- Beat counter increments on each transfer. SOP = (beat==0) & valid; EOP = (beat==`OUT_COUNT`-1) & valid. For `OUT_COUNT`=1, SOP and EOP are on the same beat.
- Backpressure: while valid & !ready, data, SOP and EOP stay stable and the FIFO does not pop.
- FIFO push and pop in the same cycle are legal; occupancy is unchanged.
- Overflow cannot occur by construction. The bench asserts that no push arrives when the FIFO is full.
- `dataAvailable_i` dropping during STREAM is ignored; the packet completes.
- `rst_i` mid-packet: everything returns to reset values next cycle. In-flight read data is discarded, and no partial EOP or `outputSent_o` is produced.

## Timing
- `dataAvailable_i` sampled high in cycle T (IDLE):
  - T+1: `memGaddr_o`=0, `memGrd_o`=1.
  - T+2: `memGrdData_i` is valid and is pushed.
  - T+3: `avst_valid_o`=1 with beat 0 and SOP.
- With `avst_ready_i` held high: one beat per cycle sustained. The last beat is at T+2+`OUT_COUNT`; `outputSent_o` fires in the next cycle.
- `outputSent_o` latency: exactly 1 cycle after the EOP transfer.
- All outputs are registered or derived from registered state. There is no combinational path from `avst_ready_i` to `avst_valid_o`.

## Configuration
- `EDGE_OUT_THRESH_EN` defined:
  - Adds input `thresh_i` [DATA_W-1:0].
  - `avst_data_o` = all-ones if head ≥ `thresh_i`, else 0 (binary edge map).
  - `thresh_i` is sampled at the IDLE→STREAM transition and held for the packet.
- Undefined: the raw gradient magnitude passes through and the `thresh_i` port is absent.

## Structure
- Shared package/header `edge_detection_pkg`:
  - FSM state encodings (IDLE=0, STREAM=1, DONE=2, WAIT_LOW=3)
  - default `DATA_W`, image width/height, derived `OUT_COUNT`
  - `ADDR_W`, shared with the controller and the G memory
- One sub-module: `edge_stream_fifo`, a 3-entry synchronous FIFO with push/pop/full/empty/count, reset to empty.

## Test plan
- `OUT_COUNT`=4, memory {10,20,30,40}, ready always 1, `dataAvailable_i` high at T → beats 10,20,30,40 at T+3..T+6, SOP with 10, EOP with 40, `outputSent_o` at T+7 only.
- Same setup with ready toggling 1,0,0,1,… → identical data order. Data, SOP and EOP are stable through stalls, and no FIFO overflow assertion fires.
- `OUT_COUNT`=1, memory {55} → one beat of 55 with SOP=EOP=1, then `outputSent_o` pulse.
- `rst_i` at beat 2 of 4 → next cycle all outputs 0 and state IDLE. A new `dataAvailable_i` restarts from address 0 with SOP.
- `dataAvailable_i` held high after `outputSent_o` → block stays in WAIT_LOW with no second packet. Dropping then re-raising `dataAvailable_i` → a new packet.
- With `EDGE_OUT_THRESH_EN`, `thresh_i`=25, memory {10,20,30,40} → beats 0x00,0x00,0xFF,0xFF.
